// File: rtl/tt_scan_ctrl.sv
// Scan-chain test controller for the DPLL: loads a pattern, runs functional
// capture clocks, unloads the chain and compares the result under a mask.
module tt_scan_ctrl #(
  parameter int CHAIN_LEN = 32
) (
  input  logic                 i_clk_gen,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [CHAIN_LEN-1:0] i_pattern,
  input  logic [7:0]           i_cap_cycles,
  input  logic [CHAIN_LEN-1:0] i_expect,
  input  logic [CHAIN_LEN-1:0] i_mask,
  output logic                 o_scan_en,
  output logic                 o_scan_in,
  input  logic                 i_scan_out,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CHAIN_LEN-1:0] o_capture,
  output logic                 o_pass
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t               state_r;
  logic [CHAIN_LEN-1:0] pat_sr_r;
  logic [CHAIN_LEN-1:0] cap_sr_r;
  logic [CHAIN_LEN-1:0] exp_r;
  logic [CHAIN_LEN-1:0] mask_r;
  logic [7:0]           ncap_r;
  logic [7:0]           cyc_cnt_r;
  logic [CW-1:0]        bit_cnt_r;

  logic                 last_bit_s;
  logic                 in_test_s;
  logic [IW-1:0]        idx_s;
  logic [CHAIN_LEN-1:0] cap_next_s;

  function automatic logic masked_match(input logic [CHAIN_LEN-1:0] cap,
                                        input logic [CHAIN_LEN-1:0] expv,
                                        input logic [CHAIN_LEN-1:0] mask);
    return (((cap ^ expv) & mask) == {CHAIN_LEN{1'b0}});
  endfunction

  assign last_bit_s = (bit_cnt_r == CW'(CHAIN_LEN - 1));
  assign in_test_s  = (state_r == ST_LOAD) || (state_r == ST_CAPTURE) || (state_r == ST_UNLOAD);
  assign idx_s      = bit_cnt_r[IW-1:0];

  // Capture word with the current pre-shift chain output merged at bit j.
  // Every bit is rewritten in order during an unload, so stale bits never leak.
  always_comb begin
    cap_next_s        = cap_sr_r;
    cap_next_s[idx_s] = i_scan_out;
  end

  // Test sequencer: state, counters, scan pins and result registers.
  always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      pat_sr_r  <= {CHAIN_LEN{1'b0}};
      cap_sr_r  <= {CHAIN_LEN{1'b0}};
      exp_r     <= {CHAIN_LEN{1'b0}};
      mask_r    <= {CHAIN_LEN{1'b0}};
      ncap_r    <= 8'd0;
      cyc_cnt_r <= 8'd0;
      bit_cnt_r <= {CW{1'b0}};
      o_scan_en <= 1'b0;
      o_scan_in <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_capture <= {CHAIN_LEN{1'b0}};
      o_pass    <= 1'b0;
    end else if (i_abort && in_test_s) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= {CW{1'b0}};
      cyc_cnt_r <= 8'd0;
      o_scan_en <= 1'b0;
      o_scan_in <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          o_done <= 1'b0;
          if (i_start && !i_abort) begin
            state_r   <= ST_LOAD;
            pat_sr_r  <= i_pattern >> 1;
            exp_r     <= i_expect;
            mask_r    <= i_mask;
            ncap_r    <= i_cap_cycles;
            bit_cnt_r <= {CW{1'b0}};
            cyc_cnt_r <= 8'd0;
            o_scan_en <= 1'b1;
            o_scan_in <= i_pattern[0];
            o_busy    <= 1'b1;
          end else begin
            state_r   <= ST_IDLE;
            o_scan_en <= 1'b0;
            o_scan_in <= 1'b0;
            o_busy    <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (last_bit_s) begin
            bit_cnt_r <= {CW{1'b0}};
            cyc_cnt_r <= 8'd0;
            o_scan_in <= 1'b0;
            if (ncap_r != 8'd0) begin
              state_r   <= ST_CAPTURE;
              o_scan_en <= 1'b0;
            end else begin
              state_r   <= ST_UNLOAD;
              o_scan_en <= 1'b1;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CW'(1);
            o_scan_in <= pat_sr_r[0];
            pat_sr_r  <= pat_sr_r >> 1;
          end
        end
        ST_CAPTURE: begin
          if (cyc_cnt_r == ncap_r - 8'd1) begin
            state_r   <= ST_UNLOAD;
            o_scan_en <= 1'b1;
          end else begin
            cyc_cnt_r <= cyc_cnt_r + 8'd1;
          end
        end
        ST_UNLOAD: begin
          cap_sr_r <= cap_next_s;
          if (last_bit_s) begin
            state_r   <= ST_DONE;
            bit_cnt_r <= {CW{1'b0}};
            o_scan_en <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            o_capture <= cap_next_s;
            o_pass    <= masked_match(cap_next_s, exp_r, mask_r);
          end else begin
            bit_cnt_r <= bit_cnt_r + CW'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          o_scan_en <= 1'b0;
          o_scan_in <= 1'b0;
          o_busy    <= 1'b0;
          o_done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_scan_ctrl.sv
// Directed bench for tt_scan_ctrl: a 32-flop chain model plus a cycle-level
// expectation queue built from the phase lengths of each test.
module tb_tt_scan_ctrl;

  localparam int N = 32;

  logic         i_clk_gen = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic         i_abort = 1'b0;
  logic [N-1:0] i_pattern = '0;
  logic [7:0]   i_cap_cycles = 8'd0;
  logic [N-1:0] i_expect = '0;
  logic [N-1:0] i_mask = '0;
  logic         i_scan_out;
  logic         o_scan_en, o_scan_in, o_busy, o_done, o_pass;
  logic [N-1:0] o_capture;

  tt_scan_ctrl #(.CHAIN_LEN(N)) dut (
    .i_clk_gen(i_clk_gen), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_pattern(i_pattern), .i_cap_cycles(i_cap_cycles), .i_expect(i_expect),
    .i_mask(i_mask), .o_scan_en(o_scan_en), .o_scan_in(o_scan_in),
    .i_scan_out(i_scan_out), .o_busy(o_busy), .o_done(o_done),
    .o_capture(o_capture), .o_pass(o_pass)
  );

  always #5 i_clk_gen = ~i_clk_gen;

  // Target chain: shifts toward bit 0 when scanning, optionally inverts when functional.
  logic [N-1:0] chain_r = '0;
  bit           chain_inv = 1'b0;
  always @(posedge i_clk_gen) begin
    if (o_scan_en) chain_r <= {o_scan_in, chain_r[N-1:1]};
    else if (chain_inv) chain_r <= ~chain_r;
  end
  assign i_scan_out = chain_r[0];

  typedef struct {
    logic         en;
    logic         sin;
    logic         busy;
    logic         done;
    logic [N-1:0] cap;
    logic         pass;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  logic [N-1:0] model_cap = '0;
  logic         model_pass = 1'b0;
  int           n_cmp = 0;
  int           n_fail = 0;
  int           busy_cyc = 0, done_cyc = 0, low_cyc = 0;
  bit           checking = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Expected per-cycle trace of one complete test, derived from phase lengths.
  task automatic push_test(input logic [N-1:0] pat, input int cap, input logic [N-1:0] expv,
                           input logic [N-1:0] mask, input bit inv);
    logic [N-1:0] res;
    for (int k = 0; k < N; k++) q.push_back('{1'b1, pat[k], 1'b1, 1'b0, '0, 1'b0});
    for (int c = 0; c < cap; c++) q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0});
    for (int k = 0; k < N; k++) q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0});
    res = (inv && (cap % 2 == 1)) ? ~pat : pat;
    q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, res, ((res ^ expv) & mask) == '0});
  endtask

  // Compare the DUT against the expectation queue every cycle, #1 after the edge.
  always @(posedge i_clk_gen) begin
    #1;
    if (checking && i_rst_n) begin
      if (q.size() > 0) e = q.pop_front();
      else e = '{1'b0, 1'b0, 1'b0, 1'b0, model_cap, model_pass};
      if (e.done) begin
        model_cap  = e.cap;
        model_pass = e.pass;
      end
      check("scan_en", o_scan_en, e.en);
      check("scan_in", o_scan_in, e.sin);
      check("busy", o_busy, e.busy);
      check("done", o_done, e.done);
      check("capture", o_capture, model_cap);
      check("pass", o_pass, model_pass);
      busy_cyc += int'(o_busy);
      done_cyc += int'(o_done);
      low_cyc  += int'(o_busy && !o_scan_en);
    end
  end

  task automatic start_test(input logic [N-1:0] pat, input logic [7:0] cap,
                            input logic [N-1:0] expv, input logic [N-1:0] mask, input bit inv);
    @(negedge i_clk_gen);
    chain_inv    = inv;
    i_pattern    = pat;
    i_cap_cycles = cap;
    i_expect     = expv;
    i_mask       = mask;
    i_start      = 1'b1;
    busy_cyc = 0; done_cyc = 0; low_cyc = 0;
    push_test(pat, int'(cap), expv, mask, inv);
    @(negedge i_clk_gen);
    i_start      = 1'b0;
    i_pattern    = $urandom;
    i_expect     = $urandom;
    i_mask       = $urandom;
    i_cap_cycles = 8'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 700 && q.size() != 0; i++) @(negedge i_clk_gen);
    check("drain_timeout", 64'(q.size()), 64'd0);
    repeat (4) @(negedge i_clk_gen);
  endtask

  task automatic run_test(input logic [N-1:0] pat, input logic [7:0] cap,
                          input logic [N-1:0] expv, input logic [N-1:0] mask, input bit inv);
    start_test(pat, cap, expv, mask, inv);
    drain();
  endtask

  initial begin
    #2;
    check("rst_scan_en", o_scan_en, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_capture", o_capture, 32'h0);
    check("rst_pass", o_pass, 1'b0);
    repeat (2) @(negedge i_clk_gen);
    i_rst_n  = 1'b1;
    checking = 1'b1;
    repeat (2) @(negedge i_clk_gen);

    run_test(32'hA5C30F1E, 8'd0, 32'hA5C30F1E, 32'hFFFFFFFF, 1'b0);
    check("lb_capture", o_capture, 32'hA5C30F1E);
    check("lb_pass", o_pass, 1'b1);
    check("lb_busy_cycles", 64'(busy_cyc), 64'd64);
    check("lb_done_pulses", 64'(done_cyc), 64'd1);

    run_test(32'h0000FFFF, 8'd1, 32'hFFFF0000, 32'hFFFFFFFF, 1'b1);
    check("cap1_capture", o_capture, 32'hFFFF0000);
    check("cap1_low_cycles", 64'(low_cyc), 64'd1);
    check("cap1_busy_cycles", 64'(busy_cyc), 64'd65);

    run_test(32'h0000FFFF, 8'd2, 32'h0000FFFF, 32'hFFFFFFFF, 1'b1);
    check("cap2_capture", o_capture, 32'h0000FFFF);
    check("cap2_low_cycles", 64'(low_cyc), 64'd2);

    run_test(32'h13579BDF, 8'd3, 32'h13579BDF, 32'hFFFFFFFF, 1'b0);
    check("cap3_capture", o_capture, 32'h13579BDF);
    check("cap3_low_cycles", 64'(low_cyc), 64'd3);

    run_test(32'hA5C30F1E, 8'd0, 32'hA5C30F3E, 32'hFFFFFFDF, 1'b0);
    check("mask_pass", o_pass, 1'b1);
    run_test(32'hA5C30F1E, 8'd0, 32'hA5C30F3E, 32'hFFFFFFFF, 1'b0);
    check("mask_fail", o_pass, 1'b0);

    // Abort during LOAD: no completion and results untouched.
    start_test(32'h12345678, 8'd0, 32'h12345678, 32'hFFFFFFFF, 1'b0);
    repeat (9) @(negedge i_clk_gen);
    i_abort = 1'b1;
    q.delete();
    @(negedge i_clk_gen);
    i_abort = 1'b0;
    check("abort_scan_en", o_scan_en, 1'b0);
    check("abort_busy", o_busy, 1'b0);
    repeat (4) @(negedge i_clk_gen);
    check("abort_done_pulses", 64'(done_cyc), 64'd0);
    check("abort_capture", o_capture, 32'hA5C30F1E);
    run_test(32'h0F0F0F0F, 8'd0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0);
    check("post_abort_capture", o_capture, 32'h0F0F0F0F);
    check("post_abort_pass", o_pass, 1'b1);

    // Start pulse during UNLOAD with another pattern must be ignored.
    start_test(32'hDEADBEEF, 8'd0, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0);
    repeat (38) @(negedge i_clk_gen);
    i_pattern = 32'h11111111;
    i_start   = 1'b1;
    @(negedge i_clk_gen);
    i_start   = 1'b0;
    drain();
    check("busy_start_capture", o_capture, 32'hDEADBEEF);
    check("busy_start_done_pulses", 64'(done_cyc), 64'd1);
    check("busy_start_busy_cycles", 64'(busy_cyc), 64'd64);

    // Asynchronous reset mid-LOAD clears outputs without a clock edge.
    start_test(32'hCAFEF00D, 8'd0, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0);
    repeat (4) @(negedge i_clk_gen);
    @(posedge i_clk_gen);
    #3;
    i_rst_n = 1'b0;
    q.delete();
    model_cap  = '0;
    model_pass = 1'b0;
    #1;
    check("arst_scan_en", o_scan_en, 1'b0);
    check("arst_scan_in", o_scan_in, 1'b0);
    check("arst_busy", o_busy, 1'b0);
    check("arst_done", o_done, 1'b0);
    check("arst_capture", o_capture, 32'h0);
    check("arst_pass", o_pass, 1'b0);
    repeat (2) @(negedge i_clk_gen);
    i_rst_n  = 1'b1;
    done_cyc = 0;
    repeat (5) @(negedge i_clk_gen);
    check("arst_idle_scan_en", o_scan_en, 1'b0);
    check("arst_idle_busy", o_busy, 1'b0);
    check("arst_no_done", 64'(done_cyc), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
